// File: rtl/snow64_long_div_u16_by_u8_arbiter_pkg.sv
// snow64_long_div_u16_by_u8_arbiter_pkg: divider port structs plus arbiter state enum and width constants
package PkgSnow64LongDiv;
  typedef struct packed {
    logic        start;
    logic [15:0] a;
    logic [7:0]  b;
  } PortIn_LongDivU16ByU8;
  typedef struct packed {
    logic [15:0] data;
    logic        valid;
    logic        can_accept_cmd;
  } PortOut_LongDivU16ByU8;
endpackage

package PkgSnow64LongDivArbiter;
  localparam int WIDTH__A = 16;
  localparam int WIDTH__B = 8;
  localparam int WIDTH__QUOT = 16;
  localparam int MAX_NUM_REQUESTERS = 8;
  typedef enum logic [1:0] {StIdle, StStart, StWait} StateT;
endpackage

// File: rtl/snow64_long_div_u16_by_u8_arbiter_picker.sv
// snow64_round_robin_picker: first valid requester at or after the pointer, wrapping to 0
module snow64_round_robin_picker #(
  parameter int NUM_REQUESTERS = 4,
  parameter int WIDTH__REQ_ID = $clog2(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] req_i,
  input  logic [WIDTH__REQ_ID-1:0]  ptr_i,
  output logic [NUM_REQUESTERS-1:0] grant_o,
  output logic [WIDTH__REQ_ID-1:0]  idx_o,
  output logic                      any_o
);
  localparam logic [WIDTH__REQ_ID:0] N_REQ = (WIDTH__REQ_ID+1)'(NUM_REQUESTERS);
  logic [WIDTH__REQ_ID:0]   sum;
  logic [WIDTH__REQ_ID-1:0] cand;
  // scan farthest-to-nearest so the requester closest to the pointer wins
  always_comb begin
    idx_o = '0;
    sum = '0;
    cand = '0;
    for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_i} + (WIDTH__REQ_ID+1)'(i);
      cand = sum >= N_REQ ? WIDTH__REQ_ID'(sum - N_REQ) : WIDTH__REQ_ID'(sum);
      if (req_i[cand]) idx_o = cand;
    end
    any_o = |req_i;
    grant_o = any_o ? NUM_REQUESTERS'(1) << idx_o : '0;
  end
endmodule

// File: rtl/snow64_long_div_u16_by_u8_arbiter.sv
// snow64_long_div_u16_by_u8_arbiter: round-robin sharing of one external u16/u8 divider among clients
// Optional SNOW64_LONG_DIV_ARBITER_DIV_BY_ZERO_FLAG_EN: adds rsp_div_by_zero and bypasses the divider when b==0.
module snow64_long_div_u16_by_u8_arbiter
  import PkgSnow64LongDiv::*;
  import PkgSnow64LongDivArbiter::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int WIDTH__REQ_ID = $clog2(NUM_REQUESTERS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQUESTERS-1:0]           req_valid,
  input  logic [WIDTH__A*NUM_REQUESTERS-1:0]  req_a,
  input  logic [WIDTH__B*NUM_REQUESTERS-1:0]  req_b,
  output logic [NUM_REQUESTERS-1:0]           req_ready,
  output logic [NUM_REQUESTERS-1:0]           rsp_valid,
  output logic [WIDTH__QUOT-1:0]              rsp_data,
  output logic                                busy,
`ifdef SNOW64_LONG_DIV_ARBITER_DIV_BY_ZERO_FLAG_EN
  output logic                                rsp_div_by_zero,
`endif
  output PortIn_LongDivU16ByU8                div_in,
  input  PortOut_LongDivU16ByU8               div_out
);
  localparam int N = NUM_REQUESTERS;
  localparam int W = WIDTH__REQ_ID;
  StateT                       state_q, state_d;
  logic [W-1:0]                rr_q, rr_d, g_q, g_d;
  logic [WIDTH__A-1:0]         a_q, a_d;
  logic [WIDTH__B-1:0]         b_q, b_d;
  logic                        start_q, start_d;
  logic [N-1:0]                rsp_valid_q, rsp_valid_d;
  logic [WIDTH__QUOT-1:0]      rsp_data_q, rsp_data_d;
  logic [N-1:0][WIDTH__A-1:0]  a_v;
  logic [N-1:0][WIDTH__B-1:0]  b_v;
  logic [N-1:0]                pick_grant;
  logic [W-1:0]                pick_idx;
  logic                        pick_any, done;
`ifdef SNOW64_LONG_DIV_ARBITER_DIV_BY_ZERO_FLAG_EN
  logic                        zero_q, zero_d, dbz_q, dbz_d;
  assign rsp_div_by_zero = dbz_q;
`endif
  assign a_v = req_a;
  assign b_v = req_b;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign busy = state_q != StIdle;
  assign div_in = '{start: start_q, a: a_q, b: b_q};

  snow64_round_robin_picker #(.NUM_REQUESTERS(N), .WIDTH__REQ_ID(W)) u_picker (
    .req_i  (req_valid & {N{div_out.can_accept_cmd}}),
    .ptr_i  (rr_q),
    .grant_o(pick_grant),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // grant in IDLE, pulse start once, then return the divider result as a one-cycle tagged strobe
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    g_d = g_q;
    a_d = a_q;
    b_d = b_q;
    start_d = 1'b0;
    rsp_valid_d = '0;
    rsp_data_d = rsp_data_q;
    req_ready = '0;
`ifdef SNOW64_LONG_DIV_ARBITER_DIV_BY_ZERO_FLAG_EN
    zero_d = zero_q;
    done = (state_q == StWait && div_out.valid) || (state_q == StStart && zero_q);
`else
    done = state_q == StWait && div_out.valid;
`endif
    if (state_q == StIdle && pick_any && !rst) begin
      req_ready = pick_grant;
      g_d = pick_idx;
      a_d = a_v[pick_idx];
      b_d = b_v[pick_idx];
      state_d = StStart;
`ifdef SNOW64_LONG_DIV_ARBITER_DIV_BY_ZERO_FLAG_EN
      zero_d = b_v[pick_idx] == '0;
      start_d = b_v[pick_idx] != '0;
`else
      start_d = 1'b1;
`endif
    end
    if (state_q == StStart) state_d = StWait;
    if (done) begin
      rsp_valid_d = N'(1) << g_q;
      rsp_data_d = state_q == StWait ? div_out.data : '0;
      rr_d = g_q == W'(N - 1) ? '0 : g_q + 1'b1;
      state_d = StIdle;
    end
`ifdef SNOW64_LONG_DIV_ARBITER_DIV_BY_ZERO_FLAG_EN
    dbz_d = done && zero_q;
`endif
  end

  // state and captured request registers; reset discards any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rr_q <= '0;
      g_q <= '0;
      a_q <= '0;
      b_q <= '0;
      start_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q <= '0;
`ifdef SNOW64_LONG_DIV_ARBITER_DIV_BY_ZERO_FLAG_EN
      zero_q <= 1'b0;
      dbz_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      g_q <= g_d;
      a_q <= a_d;
      b_q <= b_d;
      start_q <= start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
`ifdef SNOW64_LONG_DIV_ARBITER_DIV_BY_ZERO_FLAG_EN
      zero_q <= zero_d;
      dbz_q <= dbz_d;
`endif
    end
  end
endmodule

// File: doc/snow64_long_div_u16_by_u8_arbiter.md
Name: snow64_long_div_u16_by_u8_arbiter

Overview:
- Shares one Snow64LongDivU16ByU8Radix16 instance among NUM_REQUESTERS clients (e.g. per-lane integer divide units in the vector ALU).
- Round-robin grant. Drives the divider's start/a/b and waits for its completion.
- Returns the quotient to the granted requester as a one-cycle tagged pulse.
- One division in flight at a time; the divider itself is instantiated outside this block.

Parameters:
- NUM_REQUESTERS, 4, number of clients; legal range 2..8.
- WIDTH__REQ_ID, $clog2(NUM_REQUESTERS), width of the requester index.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  NUM_REQUESTERS  per-client request valid (level, held until accepted)
- req_a  in  16*NUM_REQUESTERS  dividend; client k occupies [16k+15:16k]
- req_b  in  8*NUM_REQUESTERS  divisor; client k occupies [8k+7:8k]
- req_ready  out  NUM_REQUESTERS  one-hot accept; transfer when req_valid[k]&req_ready[k]
- rsp_valid  out  NUM_REQUESTERS  one-hot, one-cycle result strobe
- rsp_data  out  16  quotient; valid only while any rsp_valid bit is set
- busy  out  1  high in any state other than IDLE
- div_in  out  PortIn_LongDivU16ByU8  start/a/b to the divider
- div_out  in  PortOut_LongDivU16ByU8  data/valid/can_accept_cmd from the divider

Behaviour:
- Reset values: state=IDLE, rr pointer=0, req_ready=0, rsp_valid=0, rsp_data=0, busy=0, div_in.start=0, div_in.a=0, div_in.b=0.
- FSM states: IDLE, START, WAIT.
- IDLE:
  - If any req_valid is set and div_out.can_accept_cmd=1, pick a winner g by round-robin.
  - Search starts at the rr pointer and wraps at NUM_REQUESTERS-1 -> 0.
  - req_ready[g]=1 combinationally, this cycle only.
  - On the clock edge: latch a/b/g, set div_in.start<=1, go to START.
  - If div_out.can_accept_cmd=0, no grant and req_ready stays all-zero.
- START:
  - div_in.start=1 for exactly one cycle.
  - Next state WAIT, div_in.start<=0.
- WAIT:
  - When div_out.valid=1: rsp_data<=div_out.data, rsp_valid[g]<=1, rr pointer<=(g+1) mod NUM_REQUESTERS, state<=IDLE.
  - The divider clears valid on the start edge, so the first WAIT cycle always sees valid=0.
- Latency: handshake in cycle 0 -> start in cycle 1 -> divider works in cycles 2-5 -> valid seen in cycle 6 -> rsp_valid in cycle 7.
  - Handshake-to-response is 7 cycles, fixed.
- Back-to-back: the IDLE cycle that carries rsp_valid may grant a new request. Sustained throughput is one division per 7 cycles.
- Divisor 0: forwarded unchanged. The divider returns 0, and that value is passed through.
- Reset mid-operation:
  - Any captured request and response is discarded; no rsp_valid is issued.
  - The divider has no reset and may still be working. After reset, IDLE blocks grants until div_out.can_accept_cmd=1.
- A requester that drops req_valid before req_ready is not granted. Dropping it is a protocol violation, but it is harmless.
- No response backpressure: a client must accept rsp_valid in the cycle it is strobed.

Optional Feature:
- Macro: SNOW64_LONG_DIV_ARBITER_DIV_BY_ZERO_FLAG_EN.
- Defined:
  - Adds output rsp_div_by_zero (1 bit, reset 0).
  - The flag is latched at grant as (b==0) and strobed alongside rsp_valid.
  - The divider is bypassed for b==0: IDLE -> WAIT is skipped, rsp_data=0 is returned 2 cycles after the handshake, and div_in.start is never raised.
- Not defined: the port is absent, and b==0 takes the normal 7-cycle path returning 0.

Decomposition:
- Package PkgSnow64LongDivArbiter holds:
  - the state enum (StIdle, StStart, StWait)
  - the width constants for a (16), b (8) and quotient (16)
  - the MAX_NUM_REQUESTERS=8 constant
- It reuses PkgSnow64LongDiv port structs.
- Sub-module snow64_round_robin_picker (combinational, parameterized by NUM_REQUESTERS):
  - inputs: request vector and pointer
  - outputs: one-hot grant, index and any-valid flag

Test Plan:
- Single request: client 1, a=1000, b=7 -> req_ready[1] pulses in cycle 0; rsp_valid=4'b0010 in cycle 7; rsp_data=0x008E (142).
- Contention: clients 0 and 2 both request a=0xFFFF, b=0xFF at reset -> grant order is 0 then 2; responses 0x0101 in cycles 7 and 14; the rr pointer then favours client 3.
- All four clients request continuously -> grants rotate 0,1,2,3,0; each rsp_valid has exactly one hot bit; no starvation over 40 grants.
- Divisor zero: a=0x1234, b=0 -> rsp_data=0 at cycle 7. With the flag macro: cycle 2, rsp_div_by_zero=1, div_in.start never asserted.
- Reset mid-op: assert rst in cycle 3 of a divide, release in cycle 4 -> no rsp_valid. A pending request is granted only once div_out.can_accept_cmd=1, then completes correctly (a=100, b=9 -> 11).
- Back-to-back: a new request is present when rsp_valid fires -> its req_ready pulses in that same cycle, and its response arrives exactly 7 cycles later.
